// File: rtl/mant_product_normalizer.sv
// BF16 product normalizer: 2-stage valid/ready pipeline turning a carry-save mantissa
// product plus operand exponents/signs into a packed BF16 result. Optional macro: ROUND_NEAREST_EN.
module mant_product_normalizer #(
   parameter int EXP_BIAS = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [16:0] mults,
   input  logic [16:0] multc,
   input  logic [7:0]  exp_a,
   input  logic [7:0]  exp_b,
   input  logic        sign_a,
   input  logic        sign_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [2:0]  flags
);

   logic              ready_en;
   logic              s1_valid;
   logic              s2_valid;
   logic              in_fire;
   logic              s1_adv;

   logic [16:0]       p_sum;
   logic signed [9:0] e_sum;

   logic [16:0]       s1_p;
   logic signed [9:0] s1_e;
   logic              s1_sign;
   logic              s1_zero;
   logic              s1_special;

   logic [6:0]        mant;
   logic [7:0]        mant_r;
   logic signed [9:0] e_norm;
   logic signed [9:0] e_fin;
   logic [15:0]       nxt_result;
   logic [2:0]        nxt_flags;

   logic [15:0]       s2_result;
   logic [2:0]        s2_flags;

   // in_ready stays low for the first cycle after reset releases
   assign s1_adv   = s1_valid & (~s2_valid | out_ready);
   assign in_ready = ready_en & (~s1_valid | ~s2_valid | out_ready);
   assign in_fire  = in_valid & in_ready;

   assign p_sum = mults + {multc[15:0], 1'b0};
   assign e_sum = {2'b00, exp_a} + {2'b00, exp_b} - 10'(EXP_BIAS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (in_fire)
            s1_valid <= 1'b1;
         else if (s1_adv)
            s1_valid <= 1'b0;
         if (s1_adv)
            s2_valid <= 1'b1;
         else if (out_ready)
            s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_p       <= p_sum;
         s1_e       <= e_sum;
         s1_sign    <= sign_a ^ sign_b;
         s1_zero    <= (exp_a == 8'h00) | (exp_b == 8'h00);
         s1_special <= (exp_a == 8'hFF) | (exp_b == 8'hFF);
      end
      if (s1_adv) begin
         s2_result <= nxt_result;
         s2_flags  <= nxt_flags;
      end
   end

`ifdef ROUND_NEAREST_EN
   logic guard;
   logic sticky;

   always_comb begin
      guard  = s1_p[15] ? s1_p[7] : s1_p[6];
      sticky = s1_p[15] ? |s1_p[6:0] : |s1_p[5:0];
      mant_r = {1'b0, mant} + {7'b0, guard & (sticky | mant[0])};
   end
`else
   always_comb begin
      mant_r = {1'b0, mant};
   end
`endif

   always_comb begin
      if (s1_p[15]) begin
         mant   = s1_p[14:8];
         e_norm = s1_e + 10'sd1;
      end else begin
         mant   = s1_p[13:7];
         e_norm = s1_e;
      end
   end

   // rounding carry-out leaves mant_r[6:0] at zero and bumps the exponent
   always_comb begin
      e_fin      = e_norm + $signed({9'b0, mant_r[7]});
      nxt_result = {s1_sign, e_fin[7:0], mant_r[6:0]};
      nxt_flags  = 3'b000;
      if (s1_special) begin
         nxt_result = 16'h7FC0;
         nxt_flags  = 3'b100;
      end else if (s1_zero) begin
         nxt_result = {s1_sign, 15'h0000};
      end else if (e_fin >= 10'sd255) begin
         nxt_result = {s1_sign, 8'hFF, 7'h00};
         nxt_flags  = 3'b010;
      end else if (e_fin <= 10'sd0) begin
         nxt_result = {s1_sign, 15'h0000};
         nxt_flags  = 3'b001;
      end
   end

   assign out_valid = s2_valid;
   assign result    = s2_valid ? s2_result : '0;
   assign flags     = s2_valid ? s2_flags  : '0;

endmodule

// File: tb/tb_mant_product_normalizer.sv
// Self-checking bench for mant_product_normalizer: scoreboard on every output transfer,
// plus directed spec vectors, back-pressure, stall-hold and reset-in-flight scenarios.
module tb_mant_product_normalizer;

   localparam int BIAS = 127;

`ifdef ROUND_NEAREST_EN
   localparam logic [15:0] EXP_40C0 = 16'h3F82;
   localparam logic [15:0] EXP_7FFF = 16'h4000;
`else
   localparam logic [15:0] EXP_40C0 = 16'h3F81;
   localparam logic [15:0] EXP_7FFF = 16'h3FFF;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [16:0] mults = '0;
   logic [16:0] multc = '0;
   logic [7:0]  exp_a = '0;
   logic [7:0]  exp_b = '0;
   logic        sign_a = 1'b0;
   logic        sign_b = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [2:0]  flags;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          lat_chk = 1'b0;
   bit          bp_on = 1'b0;

   logic [18:0] sb_q[$];
   int          acc_q[$];

   typedef struct {
      logic [16:0] ms;
      logic [16:0] mc;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic        sa;
      logic        sb;
      logic [15:0] res;
      logic [2:0]  fl;
   } vec_t;

   mant_product_normalizer #(.EXP_BIAS(BIAS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mults    (mults),
      .multc    (multc),
      .exp_a    (exp_a),
      .exp_b    (exp_b),
      .sign_a   (sign_a),
      .sign_b   (sign_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .flags    (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Reference model: works on the integer product and the discarded remainder.
   function automatic logic [18:0] model(input logic [16:0] ms, input logic [16:0] mc,
                                         input logic [7:0] ea, input logic [7:0] eb,
                                         input logic sa, input logic sb);
      int unsigned p, m, sh;
      int          e;
      logic        s;
      p = (32'(ms) + 32'(mc) * 2) & 32'h1FFFF;
      s = sa ^ sb;
      e = int'(ea) + int'(eb) - BIAS;
      if (ea == 8'hFF || eb == 8'hFF) return {3'b100, 16'h7FC0};
      if (ea == 8'h00 || eb == 8'h00) return {3'b000, s, 15'h0};
      sh = ((p >> 15) & 1) != 0 ? 8 : 7;
      if (sh == 8) e = e + 1;
      m = (p >> sh) & 127;
`ifdef ROUND_NEAREST_EN
      begin
         int unsigned rem, half;
         rem  = p & ((32'd1 << sh) - 1);
         half = 32'd1 << (sh - 1);
         if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      end
`endif
      if (m == 128) begin
         m = 0;
         e = e + 1;
      end
      if (e >= 255) return {3'b010, s, 8'hFF, 7'h0};
      if (e <= 0) return {3'b001, s, 15'h0};
      return {3'b000, s, 8'(e), 7'(m)};
   endfunction

   // Scoreboard: sampled on the falling edge, i.e. the values the next rising edge acts on.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL stale_output got=%h/%b required=no output", result, flags);
            end else begin
               logic [18:0] exp_v;
               int          a;
               exp_v = sb_q.pop_front();
               a = acc_q.pop_front();
               if ({flags, result} !== exp_v) begin
                  errors++;
                  $display("FAIL sb_result got=%h/%b required=%h/%b", result, flags,
                           exp_v[15:0], exp_v[18:16]);
               end
               if (lat_chk) begin
                  checks++;
                  if (cyc - a != 2) begin
                     errors++;
                     $display("FAIL latency got=%0d required=2", cyc - a);
                  end
               end
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(mults, multc, exp_a, exp_b, sign_a, sign_b));
            acc_q.push_back(cyc);
         end
         if (!out_valid) begin
            checks++;
            if (result !== 16'h0 || flags !== 3'b0) begin
               errors++;
               $display("FAIL idle_zero got=%h/%b required=0000/000", result, flags);
            end
         end
      end
   end

   task automatic drive(input logic [16:0] ms, input logic [16:0] mc, input logic [7:0] ea,
                        input logic [7:0] eb, input logic sa, input logic sb);
      bit acc;
      int n;
      n = 0;
      mults = ms; multc = mc; exp_a = ea; exp_b = eb; sign_a = sa; sign_b = sb;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout got=in_ready 0 required=accept within 200 cycles");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got=%0d pending required=0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, result, flags} !== '0) begin
         errors++;
         $display("FAIL reset_state got=rdy%b vld%b %h/%b required=all zero",
                  in_ready, out_valid, result, flags);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b required=1", in_ready);
      end
   endtask

   task automatic test_directed();
      vec_t tbl[14];
      tbl = '{
         '{17'h04000, 17'h0,     8'h7F, 8'h7F, 1'b0, 1'b0, 16'h3F80, 3'b000},
         '{17'h09000, 17'h0,     8'h7F, 8'h7F, 1'b1, 1'b0, 16'hC010, 3'b000},
         '{17'h040C0, 17'h0,     8'h7F, 8'h7F, 1'b0, 1'b0, EXP_40C0, 3'b000},
         '{17'h04040, 17'h0,     8'h7F, 8'h7F, 1'b0, 1'b0, 16'h3F80, 3'b000},
         '{17'h04000, 17'h0,     8'hFE, 8'hFE, 1'b0, 1'b0, 16'h7F80, 3'b010},
         '{17'h04000, 17'h0,     8'h01, 8'h01, 1'b0, 1'b0, 16'h0000, 3'b001},
         '{17'h04000, 17'h0,     8'hFF, 8'h7F, 1'b0, 1'b0, 16'h7FC0, 3'b100},
         '{17'h04000, 17'h0,     8'h00, 8'h7F, 1'b1, 1'b0, 16'h8000, 3'b000},
         '{17'h07FFF, 17'h0,     8'h7F, 8'h7F, 1'b0, 1'b0, EXP_7FFF, 3'b000},
         '{17'h04000, 17'h0,     8'hFE, 8'h80, 1'b0, 1'b1, 16'hFF80, 3'b010},
         '{17'h04000, 17'h0,     8'hFE, 8'h7F, 1'b0, 1'b0, 16'h7F00, 3'b000},
         '{17'h04000, 17'h0,     8'h01, 8'h7F, 1'b0, 1'b0, 16'h0080, 3'b000},
         '{17'h04000, 17'h0,     8'h01, 8'h7E, 1'b1, 1'b1, 16'h0000, 3'b001},
         '{17'h02000, 17'h01000, 8'h7F, 8'h7F, 1'b0, 1'b0, 16'h3F80, 3'b000}
      };
      out_ready = 1'b1;
      lat_chk = 1'b1;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].ms, tbl[i].mc, tbl[i].ea, tbl[i].eb, tbl[i].sa, tbl[i].sb);
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || result !== tbl[i].res || flags !== tbl[i].fl) begin
            errors++;
            $display("FAIL directed_%0d got=vld%b %h/%b required=vld1 %h/%b", i,
                     out_valid, result, flags, tbl[i].res, tbl[i].fl);
         end
      end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      lat_chk = 1'b1;
      for (int i = 0; i < 40; i++)
         drive(17'($urandom), 17'($urandom), 8'($urandom_range(60, 200)),
               8'($urandom_range(60, 200)), 1'($urandom), 1'($urandom));
      drain();
   endtask

   task automatic test_backpressure();
      lat_chk = 1'b0;
      bp_on = 1'b1;
      fork
         begin
            while (bp_on) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 60; i++)
         drive(17'($urandom), 17'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
      bp_on = 1'b0;
      drain();
   endtask

   task automatic test_stall();
      vec_t v[3];
      int   idx;
      bit   acc;
      v = '{
         '{17'h04000, 17'h0, 8'h7F, 8'h7F, 1'b0, 1'b0, 16'h3F80, 3'b000},
         '{17'h09000, 17'h0, 8'h7F, 8'h7F, 1'b1, 1'b0, 16'hC010, 3'b000},
         '{17'h04000, 17'h0, 8'hFE, 8'hFE, 1'b0, 1'b0, 16'h7F80, 3'b010}
      };
      lat_chk = 1'b0;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         mults = v[idx].ms; multc = v[idx].mc; exp_a = v[idx].ea; exp_b = v[idx].eb;
         sign_a = v[idx].sa; sign_b = v[idx].sb;
         in_valid = 1'b1;
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc && idx < 2) idx++;
      end
      checks++;
      if (idx != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_accept got=%0d accepted rdy%b required=2 accepted rdy0", idx, in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (out_valid !== 1'b1 || result !== v[0].res || flags !== v[0].fl) begin
            errors++;
            $display("FAIL stall_hold got=vld%b %h/%b required=vld1 %h/%b", out_valid,
                     result, flags, v[0].res, v[0].fl);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drive(v[2].ms, v[2].mc, v[2].ea, v[2].eb, v[2].sa, v[2].sb);
      drain();
   endtask

   task automatic test_reset_flight();
      lat_chk = 1'b0;
      out_ready = 1'b0;
      drive(17'h04000, 17'h0, 8'h7F, 8'h7F, 1'b0, 1'b0);
      drive(17'h09000, 17'h0, 8'h7F, 8'h7F, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flight_reset got=vld%b %h rdy%b required=vld0 0000 rdy0",
                  out_valid, result, in_ready);
      end
      sb_q.delete();
      acc_q.delete();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flight_ready got=%b required=1", in_ready);
      end
      repeat (5) @(posedge clk);
      #1;
      lat_chk = 1'b1;
      drive(17'h04040, 17'h0, 8'h80, 8'h7F, 1'b1, 1'b1);
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_stall();
      test_reset_flight();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mant_product_normalizer.md
MANT_PRODUCT_NORMALIZER -- requirements
Module: mant_product_normalizer

Interface
REQ-001 The module SHALL have parameter EXP_BIAS, default 127, the exponent bias subtracted from the exponent sum.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-004 The module SHALL have port in_valid, input, 1, meaning the upstream operand set is valid.
REQ-005 The module SHALL have port in_ready, output, 1, meaning an operand set is accepted this cycle.
REQ-006 The module SHALL have ports mults and multc, input, 17 each, the carry-save product from the mantissa multiplier.
REQ-007 The module SHALL have ports exp_a and exp_b, input, 8 each, the biased BF16 operand exponents.
REQ-008 The module SHALL have ports sign_a and sign_b, input, 1 each, the operand signs.
REQ-009 The module SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The module SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 The module SHALL have port result, output, 16, the BF16 product {sign, exp[7:0], mant[6:0]}.
REQ-012 The module SHALL have port flags, output, 3, the sticky-free per-result flags {nan, overflow, underflow}.

Function
REQ-013 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output); the module is a 2-stage valid/ready pipeline, S1 then S2.
REQ-014 in_ready SHALL equal !s1_valid | (!s2_valid | out_ready); S1 advances into S2 whenever S2 is empty or draining, so full throughput is one result/cycle.
REQ-015 S1 SHALL register P = (mults + (multc << 1)) mod 2^17, E = exp_a + exp_b - EXP_BIAS as 10-bit signed, and S = sign_a ^ sign_b.
REQ-016 S1 SHALL also register zero = (exp_a==0)|(exp_b==0) and special = (exp_a==8'hFF)|(exp_b==8'hFF).
REQ-017 S2 normalization: if P[15]=1 then mant=P[14:8], guard=P[7], sticky=|P[6:0], E=E+1; else mant=P[13:7], guard=P[6], sticky=|P[5:0].
REQ-018 Rounding SHALL be per the Configuration section; a mantissa carry-out from rounding SHALL give mant=0 and E=E+1.
REQ-019 Priority: special -> result 16'h7FC0, flags=3'b100; else zero -> {S,15'h0}, flags=0; else E>=255 after rounding -> {S,8'hFF,7'h0}, flags=3'b010; else E<=0 -> {S,15'h0}, flags=3'b001; else {S,E[7:0],mant}, flags=0.
REQ-020 Latency SHALL be 2 cycles from input acceptance to out_valid when out_ready is held high.
REQ-021 While out_valid=1 and out_ready=0, result and flags SHALL be held stable and no held entry SHALL be overwritten or dropped.
REQ-022 Results SHALL leave in acceptance order; simultaneous accept and emit in one cycle SHALL be legal.

Reset
REQ-023 rst_n=0 at a clock edge SHALL clear both stage valid bits; in_ready, out_valid, result and flags then read 0 (in_ready returns to 1 on the cycle after reset deasserts).
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries; no result from before reset is ever emitted.
REQ-025 Datapath registers other than valid bits MAY be left unreset, but result SHALL be forced to 0 while out_valid=0.

Configuration
REQ-026 With macro ROUND_NEAREST_EN defined, S2 SHALL round up when guard & (sticky | mant[0]) (round-to-nearest-even).
REQ-027 Without ROUND_NEAREST_EN, S2 SHALL truncate (guard and sticky ignored); all other behaviour is identical.

Verification
REQ-028 mults=17'h04000, multc=0, exp_a=exp_b=8'h7F, signs 0 -> result 16'h3F80, flags 0, out_valid exactly 2 cycles after accept.
REQ-029 mults=17'h09000, multc=0, exp 8'h7F/8'h7F, sign_a=1 -> result 16'hC010 (-2.25), flags 0.
REQ-030 P=16'h40C0 (via mults=17'h040C0, multc=0), exp 8'h7F/8'h7F -> 16'h3F82 with ROUND_NEAREST_EN, 16'h3F81 without; P=16'h4040 -> 16'h3F80 both builds (tie to even).
REQ-031 exp_a=exp_b=8'hFE, P=16'h4000 -> 16'h7F80, flags 3'b010; exp_a=exp_b=8'h01 -> 16'h0000, flags 3'b001; exp_a=8'hFF -> 16'h7FC0, flags 3'b100.
REQ-032 Three back-to-back inputs with out_ready=0 for 4 cycles -> exactly two accepted, in_ready=0 thereafter, result held stable; out_ready=1 then yields all three in order with no loss.
REQ-033 rst_n=0 for one cycle while two entries are in flight -> out_valid=0 next cycle, no stale result ever emitted, in_ready=1 the cycle after reset deasserts.
